// File: rtl/line_clear_seq_if.sv
// rtl/line_clear_seq_if.sv - board-memory port between the line-clear sequencer and the playfield RAM
interface line_clear_seq_if #(
   parameter int AW   = 5,
   parameter int COLS = 10
);
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic [COLS-1:0] rd_data;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [COLS-1:0] wr_data;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data
   );
endinterface

// File: rtl/line_clear_seq.sv
// rtl/line_clear_seq.sv - remove-phase sequencer: detects full rows, compacts the board, zero-fills the top
module line_clear_seq #(
   parameter int ROWS = 20,
   parameter int COLS = 10,
   parameter int AW   = 5,
   parameter int TW   = 16
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                start,
   line_clear_seq_if.master    bus,
   output logic                busy,
   output logic                done,
   output logic [AW-1:0]       lines,
   output logic [TW-1:0]       total
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CHK  = 3'd2;
   localparam logic [2:0] S_FILL = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

   logic [2:0]    state;
   logic [AW-1:0] rp;
   logic [AW-1:0] wp;
   logic [AW-1:0] cnt;

   logic          in_chk;
   logic          row_full;
   logic          chk_write;
   logic [AW-1:0] cnt_next;
   logic [TW:0]   total_sum;

   assign in_chk    = (state == S_CHK);
   assign row_full  = &bus.rd_data;
   assign chk_write = in_chk && !row_full && (rp != wp);
   assign cnt_next  = cnt + AW'(in_chk && row_full);
   assign total_sum = {1'b0, total} + {{(TW + 1 - AW){1'b0}}, cnt};

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // Reads and writes live in disjoint states, so one RAM port serves both.
   assign bus.rd_en   = (state == S_RD);
   assign bus.rd_addr = rp;
   assign bus.wr_en   = chk_write || (state == S_FILL);
   assign bus.wr_addr = bus.wr_en ? wp : '0;
   assign bus.wr_data = chk_write ? bus.rd_data : '0;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= S_IDLE;
         rp    <= '0;
         wp    <= '0;
         cnt   <= '0;
         lines <= '0;
         total <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  rp    <= LAST_ROW;
                  wp    <= LAST_ROW;
                  cnt   <= '0;
                  state <= S_RD;
               end
            end
            S_RD: begin
               state <= S_CHK;
            end
            S_CHK: begin
               cnt <= cnt_next;
               // wp parks at 0 so it lands on cleared-1 when FILL starts and never wraps.
               if (!row_full && (wp != '0)) begin
                  wp <= wp - AW'(1);
               end
               if (rp == '0) begin
                  state <= (cnt_next != '0) ? S_FILL : S_DONE;
               end else begin
                  rp    <= rp - AW'(1);
                  state <= S_RD;
               end
            end
            S_FILL: begin
               if (wp == '0) begin
                  state <= S_DONE;
               end else begin
                  wp <= wp - AW'(1);
               end
            end
            S_DONE: begin
               lines <= cnt;
               total <= total_sum[TW] ? {TW{1'b1}} : total_sum[TW-1:0];
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_clear_seq.sv
// tb/tb_line_clear_seq.sv - self-checking bench for line_clear_seq against a board-compaction reference model
module tb_line_clear_seq;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int AW   = 5;
   localparam int TW   = 16;

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   logic start = 1'b0;
   logic load = 1'b0;
   logic busy;
   logic done;
   logic [AW-1:0] lines;
   logic [TW-1:0] total;

   always #5 clk = ~clk;

   line_clear_seq_if #(.AW(AW), .COLS(COLS)) bus ();

   line_clear_seq #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .TW(TW)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .lines (lines),
      .total (total)
   );

   logic [COLS-1:0] mem [ROWS];
   logic [COLS-1:0] pre [ROWS];
   logic [COLS-1:0] exp_board [ROWS];
   logic [AW+COLS-1:0] wq [$];
   logic [AW+COLS-1:0] eq [$];
   int exp_n;
   int model_total = 0;
   int errors = 0;
   int checks = 0;

   // Single-port board RAM: one-cycle read latency, write on the strobed edge.
   always @(posedge clk) begin
      if (load) begin
         for (int r = 0; r < ROWS; r++) mem[r] <= pre[r];
      end else if (bus.wr_en) begin
         mem[int'(bus.wr_addr)] <= bus.wr_data;
      end
      if (bus.rd_en) bus.rd_data <= mem[int'(bus.rd_addr)];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: surviving rows keep bottom-up order and drop by the number of full rows below them.
   task automatic build_model();
      int n = 0;
      eq.delete();
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (pre[r] == {COLS{1'b1}}) begin
            n++;
         end else begin
            exp_board[r + n] = pre[r];
            if (n != 0) eq.push_back({AW'(r + n), pre[r]});
         end
      end
      for (int i = n - 1; i >= 0; i--) begin
         exp_board[i] = '0;
         eq.push_back({AW'(i), {COLS{1'b0}}});
      end
      exp_n = n;
      model_total = (model_total + n > 65535) ? 65535 : model_total + n;
   endtask

   task automatic fill_random(input int pct_full);
      logic [COLS-1:0] v;
      for (int r = 0; r < ROWS; r++) begin
         if ($urandom_range(0, 99) < pct_full) begin
            pre[r] = '1;
         end else begin
            v = COLS'($urandom);
            if (v == {COLS{1'b1}}) v[0] = 1'b0;
            pre[r] = v;
         end
      end
   endtask

   task automatic load_and_start();
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0; start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic run_pass(input string tag, input int x1, input int x2);
      int cyc = 0;
      int dn = 0;
      int dcyc = 0;
      int coll = 0;
      int stray = 0;
      int wbad = 0;
      int bbad = 0;
      build_model();
      wq.delete();
      load_and_start();
      for (int g = 0; g < 300; g++) begin
         if (!busy) break;
         cyc++;
         if (bus.wr_en) wq.push_back({bus.wr_addr, bus.wr_data});
         if (bus.wr_en && bus.rd_en) coll++;
         if (done) begin dn++; dcyc = cyc; end
         start = (cyc == x1) || (cyc == x2);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (busy || done) stray++;
      end
      if (wq.size() != eq.size()) wbad = 1;
      else foreach (wq[i]) if (wq[i] !== eq[i]) wbad++;
      for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_board[r]) bbad++;
      check({tag, " pass_len"}, cyc, 2 * ROWS + exp_n + 1);
      check({tag, " done_cycle"}, dcyc, 2 * ROWS + exp_n + 1);
      check({tag, " done_count"}, dn, 1);
      check({tag, " lines"}, 32'(lines), exp_n);
      check({tag, " total"}, 32'(total), model_total);
      check({tag, " write_count"}, wq.size(), eq.size());
      check({tag, " write_seq_bad"}, wbad, 0);
      check({tag, " board_bad"}, bbad, 0);
      check({tag, " rd_wr_overlap"}, coll, 0);
      check({tag, " stray_busy"}, stray, 0);
   endtask

   initial begin
      for (int r = 0; r < ROWS; r++) pre[r] = '0;
      repeat (3) @(negedge clk);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst rd_en", 32'(bus.rd_en), 0);
      check("rst wr_en", 32'(bus.wr_en), 0);
      check("rst lines", 32'(lines), 0);
      check("rst total", 32'(total), 0);
      clr_n = 1'b1;
      @(negedge clk);

      // Empty board.
      for (int r = 0; r < ROWS; r++) pre[r] = '0;
      run_pass("empty", 0, 0);

      // Only the bottom row full.
      for (int r = 0; r < ROWS; r++) pre[r] = COLS'(r + 1);
      pre[19] = '1;
      pre[18] = 10'b0000000011;
      run_pass("bottom", 0, 0);

      // Scattered full rows, distinct per-row pattern, run twice.
      for (int r = 0; r < ROWS; r++) pre[r] = {AW'(r), ~AW'(r)};
      pre[19] = '1; pre[17] = '1; pre[16] = '1; pre[12] = '1;
      run_pass("four_a", 0, 0);
      run_pass("four_b", 0, 0);

      // All rows full.
      for (int r = 0; r < ROWS; r++) pre[r] = '1;
      run_pass("all_full", 0, 0);

      // start re-pulsed mid-pass and on the done cycle.
      for (int r = 0; r < ROWS; r++) pre[r] = COLS'(r * 3);
      run_pass("restart", 5, 41);

      // Reset in the middle of a pass.
      fill_random(40);
      load_and_start();
      repeat (9) @(negedge clk);
      clr_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 0);
      check("midrst done", 32'(done), 0);
      check("midrst wr_en", 32'(bus.wr_en), 0);
      check("midrst lines", 32'(lines), 0);
      check("midrst total", 32'(total), 0);
      model_total = 0;
      @(negedge clk) clr_n = 1'b1;
      @(negedge clk);
      fill_random(40);
      run_pass("after_rst", 0, 0);

      // Randomized boards.
      for (int k = 0; k < 8; k++) begin
         fill_random(int'($urandom_range(0, 60)));
         run_pass($sformatf("rand%0d", k), int'($urandom_range(0, 60)), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
